pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use interlock, branch flush
// and fetch/data memory wait handling, plus a saturating stall performance counter.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        LoadE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        imem_ready,
  output logic        imem_abort,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  // state | meaning
  // RUN   | no outstanding memory wait
  // IWAIT | instruction fetch outstanding (imem_ready low)
  // DWAIT | data memory access outstanding in Memory stage
  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_IWAIT = 2'b01;
  localparam logic [1:0] S_DWAIT = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        lduse, dwait, iwait;
  logic        fwd_m_a, fwd_w_a, fwd_m_b, fwd_w_b;

  // x0 is hardwired zero, so it never forwards and never interlocks
  assign fwd_m_a = RegWriteM && (RdM != 5'd0) && (RdM == Rs1E);
  assign fwd_w_a = RegWriteW && (RdW != 5'd0) && (RdW == Rs1E);
  assign fwd_m_b = RegWriteM && (RdM != 5'd0) && (RdM == Rs2E);
  assign fwd_w_b = RegWriteW && (RdW != 5'd0) && (RdW == Rs2E);

  assign ForwardAE = fwd_m_a ? 2'b10 : (fwd_w_a ? 2'b01 : 2'b00);
  assign ForwardBE = fwd_m_b ? 2'b10 : (fwd_w_b ? 2'b01 : 2'b00);

  assign lduse = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign dwait = dmem_req && !dmem_ready;
  assign iwait = !imem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (dwait)                 state_d = S_DWAIT;
        else if (iwait && !PCSrcE) state_d = S_IWAIT;
      end
      S_IWAIT: begin
        if (dwait)                       state_d = S_DWAIT;
        else if (imem_ready || PCSrcE)   state_d = S_RUN;
      end
      S_DWAIT: begin
        if (dmem_ready) state_d = iwait ? S_IWAIT : S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Stall/flush depend only on the hazard priority; state only gates the abort
  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    imem_abort = 1'b0;
    if (dwait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD     = 1'b1;
      FlushE     = 1'b1;
      imem_abort = (state_q == S_IWAIT);
    end else if (lduse) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (iwait) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  assign stall_cnt_d = (StallF && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= 16'd0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
